// File: rtl/airi5c_imm_gen_pipe_pkg.sv
// Shared types for the pipelined immediate generator: format-select codes and helpers.
package airi5c_imm_gen_pipe_pkg;

  localparam int IMM_TYPE_WIDTH = 4;

  // I/S/U/J keep their legacy 2-bit codes so existing decoders need no change.
  typedef enum logic [IMM_TYPE_WIDTH-1:0] {
    IMM_I     = 4'd0,
    IMM_S     = 4'd1,
    IMM_U     = 4'd2,
    IMM_J     = 4'd3,
    IMM_B     = 4'd4,
    IMM_Z     = 4'd5,
    IMM_CI    = 4'd6,
    IMM_CIU   = 4'd7,
    IMM_C16SP = 4'd8,
    IMM_CLWSP = 4'd9,
    IMM_CSWSP = 4'd10,
    IMM_CIW   = 4'd11,
    IMM_CLS   = 4'd12,
    IMM_CB    = 4'd13,
    IMM_CJ    = 4'd14
  } imm_type_e;

  function automatic logic is_rvc_type(logic [IMM_TYPE_WIDTH-1:0] t);
    return (t >= IMM_CI) && (t <= IMM_CJ);
  endfunction

endpackage

// File: rtl/airi5c_imm_gen_pipe_if.sv
// Handshake bundle between decode (in side) and the execute operand muxes (out side).
interface airi5c_imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic                                              in_valid_i;
  logic                                              in_ready_o;
  logic [31:0]                                       inst_i;
  logic [airi5c_imm_gen_pipe_pkg::IMM_TYPE_WIDTH-1:0] imm_type_i;
  logic                                              out_valid_o;
  logic                                              out_ready_i;
  logic [XLEN-1:0]                                   imm_o;
  logic                                              illegal_o;

  modport slave (
    input  in_valid_i, inst_i, imm_type_i, out_ready_i,
    output in_ready_o, out_valid_o, imm_o, illegal_o
  );

  modport master (
    output in_valid_i, inst_i, imm_type_i, out_ready_i,
    input  in_ready_o, out_valid_o, imm_o, illegal_o
  );
endinterface

// File: rtl/airi5c_imm_gen_pipe_extract.sv
// Combinational immediate extraction for all RV32/64 base and RVC formats.
module airi5c_imm_extract
  import airi5c_imm_gen_pipe_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter bit          RVC_EN   = 1'b1,
  parameter logic [31:0] DEAD_VAL = 32'hdeadbeef
) (
  input  logic [31:0]               inst_i,
  input  logic [IMM_TYPE_WIDTH-1:0] imm_type_i,
  output logic [XLEN-1:0]           imm_o,
  output logic                      illegal_o
);

  logic [31:0] imm32;
  logic        known;
  logic        ill;

  // Zero-extended formats never set bit 31, so one sign-extension covers every case.
  always_comb begin
    imm32 = 32'd0;
    known = 1'b1;
    case (imm_type_i)
      IMM_I:     imm32 = 32'($signed(inst_i[31:20]));
      IMM_S:     imm32 = 32'($signed({inst_i[31:25], inst_i[11:7]}));
      IMM_B:     imm32 = 32'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
      IMM_U:     imm32 = {inst_i[31:12], 12'b0};
      IMM_J:     imm32 = 32'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
      IMM_Z:     imm32 = 32'(inst_i[19:15]);
      IMM_CI:    imm32 = 32'($signed({inst_i[12], inst_i[6:2]}));
      IMM_CIU:   imm32 = 32'($signed({inst_i[12], inst_i[6:2], 12'b0}));
      IMM_C16SP: imm32 = 32'($signed({inst_i[12], inst_i[4:3], inst_i[5], inst_i[2], inst_i[6], 4'b0}));
      IMM_CLWSP: imm32 = 32'({inst_i[3:2], inst_i[12], inst_i[6:4], 2'b0});
      IMM_CSWSP: imm32 = 32'({inst_i[8:7], inst_i[12:9], 2'b0});
      IMM_CIW:   imm32 = 32'({inst_i[10:7], inst_i[12:11], inst_i[5], inst_i[6], 2'b0});
      IMM_CLS:   imm32 = 32'({inst_i[5], inst_i[12:10], inst_i[6], 2'b0});
      IMM_CB:    imm32 = 32'($signed({inst_i[12], inst_i[6:5], inst_i[2], inst_i[11:10],
                                      inst_i[4:3], 1'b0}));
      IMM_CJ:    imm32 = 32'($signed({inst_i[12], inst_i[8], inst_i[10:9], inst_i[6], inst_i[7],
                                      inst_i[2], inst_i[11], inst_i[5:3], 1'b0}));
      default:   known = 1'b0;
    endcase

    ill = !known || (!RVC_EN && is_rvc_type(imm_type_i));
    if (ill) imm_o = XLEN'(DEAD_VAL);
    else     imm_o = XLEN'($signed(imm32));
    illegal_o = ill;
  end

  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst_i[1:0], inst_i[15:13]};

endmodule

// File: rtl/airi5c_imm_gen_pipe.sv
// Pipelined immediate generator: extraction followed by STAGES valid/ready register slices.
module airi5c_imm_gen_pipe
  import airi5c_imm_gen_pipe_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          STAGES   = 1,
  parameter bit          RVC_EN   = 1'b1,
  parameter logic [31:0] DEAD_VAL = 32'hdeadbeef
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  airi5c_imm_gen_pipe_if.slave   bus
);

  logic [XLEN-1:0]   ext_imm;
  logic              ext_ill;

  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_ill;
  logic [XLEN-1:0]   stage_imm [STAGES];
  logic [STAGES-1:0] stage_rdy;
  logic              rdy_acc;

  airi5c_imm_extract #(
    .XLEN     (XLEN),
    .RVC_EN   (RVC_EN),
    .DEAD_VAL (DEAD_VAL)
  ) u_extract (
    .inst_i     (bus.inst_i),
    .imm_type_i (bus.imm_type_i),
    .imm_o      (ext_imm),
    .illegal_o  (ext_ill)
  );

  // A slice can take a beat when empty or when its successor takes its current beat.
  always_comb begin
    rdy_acc   = bus.out_ready_i;
    stage_rdy = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy_acc      = !stage_valid[k] || rdy_acc;
      stage_rdy[k] = rdy_acc;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic            up_valid;
    logic [XLEN-1:0] up_imm;
    logic            up_ill;
    logic            load;
    logic            valid_q, valid_d;
    logic            ill_q, ill_d;
    logic [XLEN-1:0] imm_q, imm_d;

    if (k == 0) begin : g_head
      assign up_valid = bus.in_valid_i;
      assign up_imm   = ext_imm;
      assign up_ill   = ext_ill;
    end else begin : g_body
      assign up_valid = stage_valid[k-1];
      assign up_imm   = stage_imm[k-1];
      assign up_ill   = stage_ill[k-1];
    end

    assign load = up_valid && stage_rdy[k] && !flush_i;

    // Flush only drops valids; data registers keep their contents.
    always_comb begin
      valid_d = valid_q;
      imm_d   = imm_q;
      ill_d   = ill_q;
      if (flush_i)           valid_d = 1'b0;
      else if (stage_rdy[k]) valid_d = up_valid;
      if (load) begin
        imm_d = up_imm;
        ill_d = up_ill;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
        imm_q   <= '0;
        ill_q   <= 1'b0;
      end else begin
        valid_q <= valid_d;
        imm_q   <= imm_d;
        ill_q   <= ill_d;
      end
    end

    assign stage_valid[k] = valid_q;
    assign stage_imm[k]   = imm_q;
    assign stage_ill[k]   = ill_q;
  end

  assign bus.in_ready_o  = stage_rdy[0] || flush_i;
  assign bus.out_valid_o = stage_valid[STAGES-1];
  assign bus.imm_o       = stage_imm[STAGES-1];
  assign bus.illegal_o   = stage_ill[STAGES-1];

endmodule

// File: tb/tb_airi5c_imm_gen_pipe.sv
// Bench for airi5c_imm_gen_pipe: three configurations driven side by side, checked against an arithmetic model.
module tb_airi5c_imm_gen_pipe;
  import airi5c_imm_gen_pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic        drv_valid [3];
  logic [31:0] drv_inst  [3];
  logic [3:0]  drv_type  [3];
  logic        drv_oready[3];
  logic [63:0] obs_imm   [3];
  logic        obs_valid [3];
  logic        obs_ill   [3];
  logic        obs_inrdy [3];

  // dut 0: XLEN32/1 slice/RVC on; dut 1: XLEN32/2 slices/RVC on; dut 2: XLEN64/2 slices/RVC off
  airi5c_imm_gen_pipe_if #(.XLEN(32)) if_a();
  airi5c_imm_gen_pipe_if #(.XLEN(32)) if_b();
  airi5c_imm_gen_pipe_if #(.XLEN(64)) if_c();

  airi5c_imm_gen_pipe #(.XLEN(32), .STAGES(1), .RVC_EN(1'b1), .DEAD_VAL(32'hdeadbeef))
    dut_a (.clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(if_a));
  airi5c_imm_gen_pipe #(.XLEN(32), .STAGES(2), .RVC_EN(1'b1), .DEAD_VAL(32'hdeadbeef))
    dut_b (.clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(if_b));
  airi5c_imm_gen_pipe #(.XLEN(64), .STAGES(2), .RVC_EN(1'b0), .DEAD_VAL(32'hdeadbeef))
    dut_c (.clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(if_c));

  assign if_a.in_valid_i = drv_valid[0];  assign if_a.inst_i = drv_inst[0];
  assign if_a.imm_type_i = drv_type[0];   assign if_a.out_ready_i = drv_oready[0];
  assign if_b.in_valid_i = drv_valid[1];  assign if_b.inst_i = drv_inst[1];
  assign if_b.imm_type_i = drv_type[1];   assign if_b.out_ready_i = drv_oready[1];
  assign if_c.in_valid_i = drv_valid[2];  assign if_c.inst_i = drv_inst[2];
  assign if_c.imm_type_i = drv_type[2];   assign if_c.out_ready_i = drv_oready[2];

  assign obs_imm[0] = {32'd0, if_a.imm_o};  assign obs_valid[0] = if_a.out_valid_o;
  assign obs_ill[0] = if_a.illegal_o;       assign obs_inrdy[0] = if_a.in_ready_o;
  assign obs_imm[1] = {32'd0, if_b.imm_o};  assign obs_valid[1] = if_b.out_valid_o;
  assign obs_ill[1] = if_b.illegal_o;       assign obs_inrdy[1] = if_b.in_ready_o;
  assign obs_imm[2] = if_c.imm_o;           assign obs_valid[2] = if_c.out_valid_o;
  assign obs_ill[2] = if_c.illegal_o;       assign obs_inrdy[2] = if_c.in_ready_o;

  int          n_vec = 0, n_err = 0;
  int          emitted[3];
  logic        in_fired[3];
  logic        hold_v[3];
  logic [63:0] hold_imm[3];
  logic [64:0] q0[$], q1[$], q2[$];

  function automatic int qsize(int d);
    if (d == 0) return q0.size();
    if (d == 1) return q1.size();
    return q2.size();
  endfunction

  function automatic void qpush(int d, logic [64:0] v);
    if (d == 0) q0.push_back(v);
    else if (d == 1) q1.push_back(v);
    else q2.push_back(v);
  endfunction

  function automatic logic [64:0] qpop(int d);
    if (d == 0) return q0.pop_front();
    if (d == 1) return q1.pop_front();
    return q2.pop_front();
  endfunction

  // Reference: immediates as signed offsets built from weighted instruction fields.
  function automatic longint fld(logic [31:0] i, int hi, int lo);
    return longint'((i >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1));
  endfunction

  function automatic longint sx(longint u, int w);
    return (u >= (longint'(1) << (w - 1))) ? u - (longint'(1) << w) : u;
  endfunction

  function automatic logic [64:0] model(logic [31:0] i, logic [3:0] t, bit xl64, bit rvc);
    longint v = 0;
    bit     ill = 0;
    case (t)
      IMM_I:     v = sx(fld(i, 31, 20), 12);
      IMM_S:     v = sx(fld(i, 31, 25) * 32 + fld(i, 11, 7), 12);
      IMM_B:     v = sx(fld(i, 31, 31) * 4096 + fld(i, 7, 7) * 2048 + fld(i, 30, 25) * 32
                        + fld(i, 11, 8) * 2, 13);
      IMM_U:     v = sx(fld(i, 31, 12), 20) * 4096;
      IMM_J:     v = sx(fld(i, 31, 31) * 1048576 + fld(i, 19, 12) * 4096 + fld(i, 20, 20) * 2048
                        + fld(i, 30, 21) * 2, 21);
      IMM_Z:     v = fld(i, 19, 15);
      IMM_CI:    v = sx(fld(i, 12, 12) * 32 + fld(i, 6, 2), 6);
      IMM_CIU:   v = sx(fld(i, 12, 12) * 32 + fld(i, 6, 2), 6) * 4096;
      IMM_C16SP: v = sx(fld(i, 12, 12) * 512 + fld(i, 4, 3) * 128 + fld(i, 5, 5) * 64
                        + fld(i, 2, 2) * 32 + fld(i, 6, 6) * 16, 10);
      IMM_CLWSP: v = fld(i, 3, 2) * 64 + fld(i, 12, 12) * 32 + fld(i, 6, 4) * 4;
      IMM_CSWSP: v = fld(i, 8, 7) * 64 + fld(i, 12, 9) * 4;
      IMM_CIW:   v = fld(i, 10, 7) * 64 + fld(i, 12, 11) * 16 + fld(i, 5, 5) * 8 + fld(i, 6, 6) * 4;
      IMM_CLS:   v = fld(i, 5, 5) * 64 + fld(i, 12, 10) * 8 + fld(i, 6, 6) * 4;
      IMM_CB:    v = sx(fld(i, 12, 12) * 256 + fld(i, 6, 5) * 64 + fld(i, 2, 2) * 32
                        + fld(i, 11, 10) * 8 + fld(i, 4, 3) * 2, 9);
      IMM_CJ:    v = sx(fld(i, 12, 12) * 2048 + fld(i, 8, 8) * 1024 + fld(i, 10, 9) * 256
                        + fld(i, 6, 6) * 128 + fld(i, 7, 7) * 64 + fld(i, 2, 2) * 32
                        + fld(i, 11, 11) * 16 + fld(i, 5, 3) * 2, 12);
      default:   ill = 1;
    endcase
    if (t >= 4'd6 && t <= 4'd14 && !rvc) ill = 1;
    if (ill) v = 64'h00000000deadbeef;
    if (!xl64) v = v & 64'h00000000ffffffff;
    return {ill, 64'(v)};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: evaluate handshakes just before the edge, then advance to the next falling edge.
  task automatic step();
    logic [64:0] e;
    #1;
    for (int d = 0; d < 3; d++) begin
      if (hold_v[d]) begin
        chk($sformatf("hold_valid%0d", d), 64'(obs_valid[d]), 64'd1);
        chk($sformatf("hold_imm%0d", d), obs_imm[d], hold_imm[d]);
      end
      if (obs_valid[d] && drv_oready[d] && !rst) begin
        chk($sformatf("out_expected%0d", d), 64'(qsize(d) != 0), 64'd1);
        if (qsize(d) != 0) begin
          e = qpop(d);
          chk($sformatf("out_imm%0d", d), obs_imm[d], e[63:0]);
          chk($sformatf("out_ill%0d", d), 64'(obs_ill[d]), 64'(e[64]));
          emitted[d]++;
        end
      end
      in_fired[d] = drv_valid[d] && obs_inrdy[d] && !flush && !rst;
      if (in_fired[d]) qpush(d, model(drv_inst[d], drv_type[d], d == 2, d != 2));
      hold_v[d]   = obs_valid[d] && !drv_oready[d] && !flush && !rst;
      hold_imm[d] = obs_imm[d];
    end
    if (flush || rst) begin
      q0.delete(); q1.delete(); q2.delete();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      drv_valid[d]  = 1'b0;
      drv_oready[d] = 1'b1;
    end
  endtask

  task automatic dir(int d, int lat, logic [31:0] inst, logic [3:0] t,
                     logic [63:0] exp, logic exp_ill, string tag);
    idle_all();
    drv_valid[d] = 1'b1;
    drv_inst[d]  = inst;
    drv_type[d]  = t;
    step();
    drv_valid[d] = 1'b0;
    repeat (lat - 1) step();
    chk({tag, "_valid"}, 64'(obs_valid[d]), 64'd1);
    chk({tag, "_imm"}, obs_imm[d], exp);
    chk({tag, "_ill"}, 64'(obs_ill[d]), 64'(exp_ill));
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, sent;
    rst = 1'b1;
    flush = 1'b0;
    for (int d = 0; d < 3; d++) begin
      drv_valid[d] = 1'b0; drv_inst[d] = 32'd0; drv_type[d] = 4'd0; drv_oready[d] = 1'b1;
      emitted[d] = 0; in_fired[d] = 1'b0; hold_v[d] = 1'b0; hold_imm[d] = 64'd0;
    end
    @(negedge clk);
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_valid%0d", d), 64'(obs_valid[d]), 64'd0);
      chk($sformatf("rst_imm%0d", d), obs_imm[d], 64'd0);
      chk($sformatf("rst_ill%0d", d), 64'(obs_ill[d]), 64'd0);
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("rst_inrdy%0d", d), 64'(obs_inrdy[d]), 64'd1);
    @(negedge clk);

    dir(0, 1, 32'hFFF00093, IMM_I,  64'hFFFFFFFF, 1'b0, "a_I");
    dir(0, 1, 32'hFE000EE3, IMM_B,  64'hFFFFFFFC, 1'b0, "a_B");
    dir(0, 1, 32'h0080006F, IMM_J,  64'h00000008, 1'b0, "a_J");
    dir(0, 1, 32'h123450B7, IMM_U,  64'h12345000, 1'b0, "a_U");
    dir(0, 1, 32'h0000BFF5, IMM_CJ, 64'hFFFFFFFC, 1'b0, "a_CJ");
    dir(0, 1, 32'h00000040, IMM_CIW, 64'h00000004, 1'b0, "a_CIW");
    dir(0, 1, 32'h12345678, 4'd15,  64'hDEADBEEF, 1'b1, "a_bad");
    dir(1, 2, 32'hFE112E23, IMM_S,  64'hFFFFFFFC, 1'b0, "b_S");
    dir(1, 2, 32'h000F8073, IMM_Z,  64'h0000001F, 1'b0, "b_Z");
    dir(2, 2, 32'h800000B7, IMM_U,  64'hFFFFFFFF80000000, 1'b0, "c_U64");
    dir(2, 2, 32'hFFF00093, IMM_I,  64'hFFFFFFFFFFFFFFFF, 1'b0, "c_I64");
    dir(2, 2, 32'h00001085, IMM_CI, 64'h00000000DEADBEEF, 1'b1, "c_norvc");

    // 8 beats into the two-slice pipe with the consumer alternating ready/not ready
    idle_all();
    base = emitted[1];
    drv_valid[1] = 1'b1; drv_inst[1] = $urandom; drv_type[1] = 4'($urandom_range(0, 14));
    sent = 1;
    for (int c = 0; c < 60 && emitted[1] - base < 8; c++) begin
      drv_oready[1] = (c % 2 == 0);
      step();
      if (in_fired[1]) begin
        if (sent < 8) begin
          drv_inst[1] = $urandom; drv_type[1] = 4'($urandom_range(0, 14)); sent++;
        end else drv_valid[1] = 1'b0;
      end
    end
    chk("bp_count", 64'(emitted[1] - base), 64'd8);

    // flush with both slices full and a third beat on offer
    idle_all();
    drv_oready[1] = 1'b0;
    drv_valid[1] = 1'b1; drv_inst[1] = 32'hFFF00093; drv_type[1] = IMM_I;
    step();
    drv_inst[1] = 32'h0080006F; drv_type[1] = IMM_J;
    step();
    drv_inst[1] = 32'h123450B7; drv_type[1] = IMM_U;
    #1 chk("full_inrdy", 64'(obs_inrdy[1]), 64'd0);
    flush = 1'b1;
    #1 chk("flush_inrdy", 64'(obs_inrdy[1]), 64'd1);
    step();
    flush = 1'b0;
    drv_valid[1] = 1'b0;
    base = emitted[1];
    chk("flush_valid", 64'(obs_valid[1]), 64'd0);
    drv_oready[1] = 1'b1;
    step();
    step();
    chk("flush_none", 64'(emitted[1] - base), 64'd0);
    dir(1, 2, 32'hFE000EE3, IMM_B, 64'hFFFFFFFC, 1'b0, "post_flush");

    // reset in the middle of a stalled stream
    for (int d = 0; d < 3; d++) begin
      drv_valid[d] = 1'b1; drv_inst[d] = $urandom; drv_type[d] = 4'($urandom_range(0, 5));
      drv_oready[d] = 1'b0;
    end
    step();
    step();
    chk("pre_rst_valid", 64'(obs_valid[0]), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_all();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("mid_rst_valid%0d", d), 64'(obs_valid[d]), 64'd0);
      chk($sformatf("mid_rst_imm%0d", d), obs_imm[d], 64'd0);
      chk($sformatf("mid_rst_inrdy%0d", d), 64'(obs_inrdy[d]), 64'd1);
    end

    // randomized traffic with random backpressure and occasional flush
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 3; d++) begin
        if (!drv_valid[d] || in_fired[d]) begin
          drv_valid[d] = ($urandom_range(0, 3) != 0);
          drv_inst[d]  = $urandom;
          drv_type[d]  = 4'($urandom_range(0, 15));
        end
        drv_oready[d] = ($urandom_range(0, 2) != 0);
      end
      flush = ($urandom_range(0, 63) == 0);
      step();
    end
    flush = 1'b0;
    idle_all();
    for (int c = 0; c < 10; c++) step();
    for (int d = 0; d < 3; d++) chk($sformatf("drain%0d", d), 64'(qsize(d)), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
